// File: rtl/apb_uart_tx.sv
// apb_uart_tx: APB slave UART transmitter.
// Bytes written to TXDATA go into a small TX FIFO. A frame state machine,
// timed by a per-bit down-counter, sends each byte LSB first on txd.
// STATUS and the level interrupt tx_irq report when the FIFO has drained.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the
// data bits, giving an 11-bit frame. Without it the frame is 8N1 (10 bits).
module apb_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        txd,
  output logic        tx_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_TXDATA = 2'd2;
  localparam logic [1:0] A_BAUD   = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Register file
  logic [1:0]    ctrl_q;
  logic [15:0]   baud_q;
  logic          ovf_q;

  // TX FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  // Frame engine
  logic [2:0]    state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   div_lat_q, div_lat_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic          access, wr_en, rd_en;
  logic [1:0]    sel;
  logic          fifo_full, fifo_empty, busy;
  logic          push_req, push, pop, ovf_set;
  logic [3:0]    cnt_field;
  logic          unused_bits;

  assign access     = PSEL & PENABLE;
  assign wr_en      = access & PWRITE;
  assign rd_en      = access & ~PWRITE;
  assign sel        = PADDR[3:2];
  assign PREADY     = access;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign busy       = (state_q != ST_IDLE);

  // A push against a full FIFO is dropped even if a pop frees a slot that edge.
  assign push_req   = wr_en & (sel == A_TXDATA);
  assign push       = push_req & ~fifo_full;
  assign ovf_set    = push_req & fifo_full;
  assign pop        = (state_q == ST_IDLE) & ctrl_q[0] & ~fifo_empty;

  assign tx_irq     = ctrl_q[1] & fifo_empty & ~busy;
  assign cnt_field  = 4'(count_q);
  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

  // Control registers: CTRL, BAUDDIV and the sticky overflow flag
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ctrl_q <= 2'b00;
      baud_q <= DEFAULT_DIV;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en && sel == A_CTRL) ctrl_q <= PWDATA[1:0];
      if (wr_en && sel == A_BAUD) baud_q <= PWDATA[15:0];
      if (ovf_set)                                      ovf_q <= 1'b1;
      else if (wr_en && sel == A_STATUS && PWDATA[3])   ovf_q <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge PCLK) begin
    if (push) mem_q[wptr_q] <= PWDATA[7:0];
  end

  // Frame sequencing: every non-idle state lasts div_lat+1 cycles
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    if (state_q == ST_IDLE) begin
      if (pop) begin
        state_d   = ST_START;
        cnt_d     = baud_q;
        div_lat_d = baud_q;
        shift_d   = mem_q[rptr_q];
        bit_d     = 3'd0;
`ifdef UART_TX_PARITY_EN
        par_d     = ^mem_q[rptr_q];
`endif
      end
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = div_lat_q;
      case (state_q)
        ST_START: state_d = ST_DATA;
        ST_DATA: begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: state_d = ST_STOP;
`endif
        ST_STOP:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state register; reset forces idle so txd returns high at once
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Frame datapath registers; only observed outside the idle state
  always_ff @(posedge PCLK) begin
    cnt_q     <= cnt_d;
    div_lat_q <= div_lat_d;
    shift_q   <= shift_d;
    bit_q     <= bit_d;
`ifdef UART_TX_PARITY_EN
    par_q     <= par_d;
`endif
  end

  // Serial line level decoded from the current frame state
  always_comb begin
    txd = 1'b1;
    case (state_q)
      ST_START:  txd = 1'b0;
      ST_DATA:   txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd = par_q;
`endif
      default:   txd = 1'b1;
    endcase
  end

  // Read mux; bus returns zero outside a read access phase
  always_comb begin
    PRDATA = 32'd0;
    if (rd_en) begin
      case (sel)
        A_CTRL:   PRDATA = {30'd0, ctrl_q};
        A_STATUS: PRDATA = {24'd0, cnt_field, ovf_q, fifo_empty, fifo_full, busy};
        A_TXDATA: PRDATA = 32'd0;
        A_BAUD:   PRDATA = {16'd0, baud_q};
        default:  PRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Testbench for apb_uart_tx: APB stimulus with a scoreboard of expected
// frames, consumed by a serial-line monitor that decodes txd.
`timescale 1ns/1ps
module tb_apb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int DEPTH = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [31:0] PADDR = 32'd0;
  logic [31:0] PWDATA = 32'd0;
  logic        PWRITE = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        txd;
  logic        tx_irq;

  apb_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd867)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
    .PREADY(PREADY), .txd(txd), .tx_irq(tx_irq)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t exp_q[$];
  int     starts[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  // reference model state
  int     model_cnt = 0;
  bit     model_ovf = 0;
  int     cur_div = 867;

  always @(posedge PCLK) cyc <= cyc + 1;

  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  function automatic logic [31:0] st_model();
    logic [31:0] s;
    s = 32'd0;
    s[7:4] = 4'(model_cnt);
    s[3] = model_ovf;
    s[2] = (model_cnt == 0);
    s[1] = (model_cnt == DEPTH);
    return s;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    PADDR = {28'd0, a, 2'b00}; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [31:0] d, output logic rdy);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0;
    PADDR = {28'd0, a, 2'b00};
    @(posedge PCLK); #1 PENABLE = 1'b1;
    #2 d = PRDATA; rdy = PREADY;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_check(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic r;
    apb_read(a, d, r);
    check(nm, d, exp);
  endtask

  // issue a TXDATA write and record what the model says will be sent
  task automatic send(input logic [7:0] b);
    if (model_cnt < DEPTH) begin
      model_cnt++;
      exp_q.push_back('{data: b, div: cur_div});
    end else begin
      model_ovf = 1'b1;
    end
    apb_write(2'd2, {$urandom_range(0, 65535), 8'h00, b});
  endtask

  task automatic set_div(input int dv);
    cur_div = dv;
    apb_write(2'd3, {$urandom_range(0, 65535), 16'(dv)});
  endtask

  task automatic wait_txd_fall(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge PCLK);
      if (txd === 1'b0) seen = 1'b1;
    end
    @(posedge PCLK); #1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL start timeout: no start bit within %0d cycles", budget);
    end
  endtask

  // wait for FIFO empty and FSM idle, then check frame count and spacing
  task automatic drain(input int nframes, input int dv);
    logic [31:0] s;
    logic r;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      apb_read(2'd1, s, r);
      if ((s & 32'h7) == 32'h4) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain timeout: status 0x%08h never reached idle+empty", s);
    end
    check("scoreboard empty", exp_q.size(), 0);
    check("frame count", starts.size(), nframes);
    for (int i = 1; i < starts.size(); i++)
      check("frame spacing", starts[i] - starts[i-1], NB * (dv + 1) + 1);
    model_cnt = 0;
  endtask

  // serial monitor: decode each frame and compare with the scoreboard head
  initial begin : monitor
    logic          prev;
    frame_t        e;
    logic [NB-1:0] bits;
    logic [7:0]    got;
    bit            ok, ab;
    prev = 1'b1;
    forever begin
      @(negedge PCLK);
      if (PRESET && prev === 1'b1 && txd === 1'b0) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected frame: start bit at cycle %0d with nothing queued", cyc);
        end else begin
          e = exp_q[0];
          bits = frame_bits(e.data);
          ok = 1'b1; ab = 1'b0; got = 8'h00;
          for (int b = 0; b < NB; b++) begin
            for (int k = 0; k <= e.div; k++) begin
              if (b != 0 || k != 0) @(negedge PCLK);
              if (!PRESET) ab = 1'b1;
              if (!ab) begin
                if (txd !== bits[b]) ok = 1'b0;
                if (k == 0 && b >= 1 && b <= 8) got[b-1] = txd;
              end
            end
          end
          if (!ab) begin
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL frame: got byte 0x%02h expected 0x%02h at div %0d (bit value or duration wrong)",
                       got, e.data, e.div);
            end
            void'(exp_q.pop_front());
          end
        end
      end
      prev = txd;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    logic        r;
    int          rise, n, lows;

    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b1;

    // reset state
    check("reset txd", txd, 1);
    check("reset tx_irq", tx_irq, 0);
    check("idle PRDATA", PRDATA, 0);
    apb_read(2'd1, d, r);
    check("reset STATUS", d, 32'h4);
    check("PREADY in access", r, 1);
    read_check("reset BAUDDIV", 2'd3, 32'd867);
    read_check("reset CTRL", 2'd0, 32'd0);
    read_check("TXDATA reads 0", 2'd2, 32'd0);

    // single frame 0xA5 at div 3 with first-frame latency
    set_div(3);
    read_check("BAUDDIV readback", 2'd3, 32'd3);
    apb_write(2'd0, 32'h1);
    read_check("CTRL readback", 2'd0, 32'h1);
    starts.delete();
    send(8'hA5);
    check("txd high at E0", txd, 1);
    @(posedge PCLK); #1;
    check("txd low after E1", txd, 0);
    drain(1, 3);
    check("irq off with IRQ_EN=0", tx_irq, 0);

    // overflow with EN=0, clear OVF, then drain four frames
    apb_write(2'd0, 32'h0);
    set_div(1);
    for (int i = 0; i < 5; i++) send(8'($urandom));
    read_check("STATUS full+ovf", 2'd1, st_model());
    check("model full status", st_model(), 32'h4A);
    apb_write(2'd1, 32'h8);
    model_ovf = 1'b0;
    read_check("STATUS ovf cleared", 2'd1, st_model());
    starts.delete();
    apb_write(2'd0, 32'h1);
    drain(4, 1);

    // interrupt timing at div 0
    set_div(0);
    apb_write(2'd0, 32'h3);
    check("irq high when idle+empty", tx_irq, 1);
    starts.delete();
    send(8'h3C);
    check("irq dropped by TXDATA write", tx_irq, 0);
    rise = -1;
    for (int k = 1; k <= 40 && rise < 0; k++) begin
      @(posedge PCLK); #1;
      if (tx_irq === 1'b1) rise = k;
    end
    check("irq rise edge", rise, NB + 1);
    drain(1, 0);

`ifdef UART_TX_PARITY_EN
    // even parity of 0x07 is 1
    set_div(1);
    apb_write(2'd0, 32'h1);
    starts.delete();
    send(8'h07);
    drain(1, 1);
`endif

    // clearing EN mid-frame finishes the frame and stops popping
    apb_write(2'd0, 32'h0);
    set_div(2);
    for (int i = 0; i < 3; i++) send(8'($urandom));
    apb_write(2'd0, 32'h1);
    wait_txd_fall(200);
    apb_write(2'd0, 32'h0);
    model_cnt = 2;
    for (int i = 0; i < 200; i++) begin
      apb_read(2'd1, d, r);
      if (d[0] == 1'b0) break;
    end
    read_check("STATUS after EN cleared", 2'd1, st_model());
    check("frames left queued", exp_q.size(), 2);
    starts.delete();
    apb_write(2'd0, 32'h1);
    drain(2, 2);

    // randomized bursts
    for (int it = 0; it < 10; it++) begin
      apb_write(2'd0, 32'h0);
      set_div($urandom_range(0, 4));
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) send(8'($urandom));
      read_check("random STATUS", 2'd1, st_model());
      if (model_ovf) begin
        apb_write(2'd1, 32'h8 | ($urandom & 32'hFFFF_FFF0));
        model_ovf = 1'b0;
      end
      starts.delete();
      apb_write(2'd0, 32'h1 | (32'($urandom_range(0, 1)) << 1));
      drain((n > DEPTH) ? DEPTH : n, cur_div);
    end

    // reset mid-DATA with two bytes still queued
    apb_write(2'd0, 32'h0);
    set_div(3);
    send(8'h00);
    send(8'h11);
    send(8'h22);
    apb_write(2'd0, 32'h1);
    wait_txd_fall(200);
    repeat (12) @(posedge PCLK);
    #1;
    check("txd low mid-DATA", txd, 0);
    PRESET = 1'b0;
    #1;
    check("txd high on async reset", txd, 1);
    check("irq low in reset", tx_irq, 0);
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    model_ovf = 1'b0;
    cur_div = 867;
    read_check("STATUS after reset", 2'd1, 32'h4);
    read_check("BAUDDIV after reset", 2'd3, 32'd867);
    read_check("CTRL after reset", 2'd0, 32'd0);
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge PCLK);
      if (txd !== 1'b1) lows++;
    end
    check("no frames after reset", lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
